operand_issue_stage: RTL

// - Decode->execute boundary. Sits downstream of the register file: takes decoded fields plus rf A/B read data,

---
 rtl/decode_pkg.sv | 32 +++
 rtl/operand_forward_mux.sv | 26 ++
 rtl/operand_issue_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared constants and record types for the decode->execute boundary.
package decode_pkg;

    localparam int XLEN      = 32;
    localparam int REG_DEPTH = 32;
    localparam int AW        = $clog2(REG_DEPTH);
    localparam int CTRL_W    = 16;
    localparam int CNT_W     = 16;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } fwd_bus_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   op_a;
        logic [XLEN-1:0]   op_b;
        logic [XLEN-1:0]   imm;
        logic [AW-1:0]     rd;
        logic              rd_we;
        logic              is_load;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_t;

    // x0 is hardwired, so a producer targeting it never supplies a value.
    function automatic logic fwd_hit(input fwd_bus_t bus, input logic [AW-1:0] rs);
        return bus.valid && (bus.rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/operand_forward_mux.sv
// Picks one source operand: youngest in-flight producer first, register file last.
module operand_forward_mux
    import decode_pkg::*;
(
    input  logic [AW-1:0]   rs,
    input  logic [XLEN-1:0] rf_data,
    input  fwd_bus_t        ex_fwd,
    input  fwd_bus_t        mem_fwd,
    input  fwd_bus_t        wb_fwd,
    output logic [XLEN-1:0] operand
);

    always_comb begin
        operand = rf_data;
        if (rs == '0) begin
            operand = '0;
        end else if (fwd_hit(ex_fwd, rs)) begin
            operand = ex_fwd.data;
        end else if (fwd_hit(mem_fwd, rs)) begin
            operand = mem_fwd.data;
        end else if (fwd_hit(wb_fwd, rs)) begin
            operand = wb_fwd.data;
        end
    end

endmodule

// File: rtl/operand_issue_stage.sv
// ID/EX boundary: operand forwarding, load-use stall, handshake and the ID/EX register.
module operand_issue_stage
    import decode_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [AW-1:0]     in_rs1,
    input  logic [AW-1:0]     in_rs2,
    input  logic              in_rs1_used,
    input  logic              in_rs2_used,
    input  logic [AW-1:0]     in_rd,
    input  logic              in_rd_we,
    input  logic              in_is_load,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [XLEN-1:0]   rf_a_data,
    input  logic [XLEN-1:0]   rf_b_data,
    input  logic              ex_fwd_valid,
    input  logic [AW-1:0]     ex_fwd_rd,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic              ex_fwd_is_load,
    input  logic              mem_fwd_valid,
    input  logic [AW-1:0]     mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_fwd_valid,
    input  logic [AW-1:0]     wb_fwd_rd,
    input  logic [XLEN-1:0]   wb_fwd_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_op_a,
    output logic [XLEN-1:0]   out_op_b,
    output logic [XLEN-1:0]   out_imm,
    output logic [AW-1:0]     out_rd,
    output logic              out_rd_we,
    output logic              out_is_load,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  hazard_stalls
);

    fwd_bus_t        ex_bus, mem_bus, wb_bus;
    logic [XLEN-1:0] op_a, op_b;

    assign ex_bus  = '{valid: ex_fwd_valid,  rd: ex_fwd_rd,  data: ex_fwd_data};
    assign mem_bus = '{valid: mem_fwd_valid, rd: mem_fwd_rd, data: mem_fwd_data};
    assign wb_bus  = '{valid: wb_fwd_valid,  rd: wb_fwd_rd,  data: wb_fwd_data};

    operand_forward_mux u_fwd_a (
        .rs      (in_rs1),
        .rf_data (rf_a_data),
        .ex_fwd  (ex_bus),
        .mem_fwd (mem_bus),
        .wb_fwd  (wb_bus),
        .operand (op_a)
    );

    operand_forward_mux u_fwd_b (
        .rs      (in_rs2),
        .rf_data (rf_b_data),
        .ex_fwd  (ex_bus),
        .mem_fwd (mem_bus),
        .wb_fwd  (wb_bus),
        .operand (op_b)
    );

    id_ex_t           id_ex_q, id_ex_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] stalls_q, stalls_d;
    logic             rs1_load_hit, rs2_load_hit, hazard, advance, accept;

    always_comb begin
        // Only sources the instruction really reads can wait on a load.
        rs1_load_hit = in_rs1_used && (in_rs1 == ex_fwd_rd);
        rs2_load_hit = in_rs2_used && (in_rs2 == ex_fwd_rd);
        hazard   = in_valid && ex_fwd_valid && ex_fwd_is_load && (ex_fwd_rd != '0)
                   && (rs1_load_hit || rs2_load_hit);
        advance  = !out_valid_q || out_ready;
        in_ready = reset && advance && !hazard && !flush;
        accept   = in_valid && in_ready;

        out_valid_d = out_valid_q;
        id_ex_d     = id_ex_q;
        stalls_d    = stalls_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (advance) begin
            out_valid_d = accept;
        end

        if (accept) begin
            id_ex_d = '{pc: in_pc, op_a: op_a, op_b: op_b, imm: in_imm, rd: in_rd,
                        rd_we: in_rd_we, is_load: in_is_load, ctrl: in_ctrl};
        end

        if (hazard && !flush && (stalls_q != '1)) begin
            stalls_d = stalls_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            id_ex_q     <= '0;
            stalls_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            id_ex_q     <= id_ex_d;
            stalls_q    <= stalls_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = id_ex_q.pc;
    assign out_op_a      = id_ex_q.op_a;
    assign out_op_b      = id_ex_q.op_b;
    assign out_imm       = id_ex_q.imm;
    assign out_rd        = id_ex_q.rd;
    assign out_rd_we     = id_ex_q.rd_we;
    assign out_is_load   = id_ex_q.is_load;
    assign out_ctrl      = id_ex_q.ctrl;
    assign hazard_stalls = stalls_q;

endmodule
